cpu_program_loader: RTL
=======================

// Module: cpu_program_loader
// PURPOSE
// - Writer side of the four-bit CPU instruction-fetch interface: accepts program words over a
//   valid/ready stream and stores them in a flop-based program memory.
// - The CPU fetches from that memory through a combinational read port.
// - Holds the CPU in reset while loading; releases it once the last word is stored.
// PARAMETERS
// - DATA_W   4   address width = CPU pc width; memory depth DEPTH = 2**DATA_W
// - INSTR_W  10  instruction word width ({6-bit opcode, 4-bit arg})
// PORTS
// - clock         in   1         rising-edge clock
// - reset         in   1         asynchronous, active-high
// - start         in   1         begin a (re)load; single-cycle pulse
// - in_valid      in   1         in_word/in_last valid
// - in_ready      out  1         loader can accept a word
// - in_word       in   INSTR_W   program word
// - in_last       in   1         marks final word of the program
// - fetch_addr    in   DATA_W    CPU pc
// - fetch_word    out  INSTR_W   instruction at fetch_addr
// - cpu_reset     out  1         reset to CPU, high = held
// - busy          out  1         load in progress
// - loaded_count  out  DATA_W+1  words stored by the current/last load
// - overflow      out  1         sticky: word(s) dropped because memory was full
// - err           out  1         checksum mismatch (optional feature); 0 otherwise
// BEHAVIOUR
// - Reset (async): state=IDLE, memory all zeros, wptr=0, loaded_count=0, overflow=0, err=0.
//   Outputs: cpu_reset=1, in_ready=0, busy=0.
// - Decode from the state flop only:
//   - cpu_reset = (state!=RUN)
//   - in_ready = busy = (state==LOAD)
// - IDLE: in_valid ignored. start -> LOAD next edge; that edge clears wptr, loaded_count,
//   overflow and err.
// - LOAD:
//   - A transfer is in_valid & in_ready at a rising edge.
//   - When wptr < DEPTH, a transfer writes mem[wptr]=in_word, then wptr++ and loaded_count++.
//   - When loaded_count==DEPTH, a transfer drops the word and sets overflow=1.
//   - start is ignored in LOAD.
//   - A transfer with in_last=1 -> RUN next edge, whether the word is stored or dropped.
// - RUN:
//   - cpu_reset=0 from the first cycle in RUN; memory is frozen.
//   - start -> LOAD next edge: cpu_reset rises one cycle after start and wptr/count/flags clear.
//   - The old program remains in memory until overwritten.
// - Fetch:
//   - fetch_word = mem[fetch_addr], combinational, valid in every state.
//   - Read and write to the same address in one cycle returns the old word; the new word
//     appears after the edge.
// - Widths:
//   - wptr is DATA_W bits and never wraps; full is detected by loaded_count==DEPTH.
//   - loaded_count saturates at DEPTH.
// - Reset mid-LOAD aborts the load immediately: memory cleared, state IDLE.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined:
//   - While in LOAD, sum = (sum + in_word) mod 2**INSTR_W over every non-last transfer,
//     including dropped words; sum clears on entry to LOAD.
//   - The in_last word is the checksum: it is neither stored nor counted.
//   - sum==in_word -> RUN.
//   - Mismatch -> ERROR: err=1, cpu_reset=1, in_ready=0. start from ERROR -> LOAD and
//     clears err.
// - LOADER_CHECKSUM_EN undefined:
//   - No ERROR state and no sum register; err tied to 0.
//   - The in_last word is stored and counted like any other word.
// TESTING
// 1. Reset, start, 11 words 0x100+i (in_last on i=10) -> loaded_count=11, RUN the cycle after
//    the last word, cpu_reset=0; fetch_addr=5 -> 0x105 (macro off).
// 2. in_valid high while in IDLE/RUN -> no write, count unchanged. In LOAD, in_valid toggled
//    every other cycle -> exactly one write per valid cycle, words in order.
// 3. DEPTH=16, 18 words, last on 18th -> loaded_count=16, overflow=1, mem[0]/mem[15] hold
//    words 0/15, RUN entered.
// 4. In RUN, pulse start -> cpu_reset=1 next cycle. Load 2 words 0x3AA,0x155 -> mem[0..1]
//    replaced, mem[2..] unchanged, cpu_reset=0 after the last word.
// 5. Assert async reset mid-LOAD after 3 words -> cpu_reset=1, in_ready=0, loaded_count=0
//    immediately, all fetch_word=0.
// 6. Macro on: 0x001,0x002,0x003, then last=0x006 -> RUN, loaded_count=3. Repeat with
//    last=0x007 -> err=1, cpu_reset stays 1; start clears err.

Source files
------------

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: writer side of the CPU instruction-fetch interface.
// Program words arrive on a valid/ready stream and are stored in a flop-based
// program memory. The CPU reads that memory through a combinational fetch port.
// The CPU is held in reset from power-up and while a load is in progress. It is
// released once the last word of the program has been taken.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, the in_last word is a checksum of the preceding words. It is not
//   stored. A mismatch parks the loader in ERROR with err=1.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   start                 single-cycle pulse that begins a (re)load
//   in_valid/in_ready     stream handshake for in_word/in_last
//   in_word, in_last      program word and end-of-program marker
//   fetch_addr/fetch_word CPU pc and the instruction stored at that address
//   cpu_reset             high while the CPU must stay in reset
//   busy                  load in progress
//   loaded_count          words stored by the current/last load (saturates at DEPTH)
//   overflow              sticky: words were dropped because memory was full
//   err                   checksum mismatch (tied low without the checksum feature)
module cpu_program_loader #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned INSTR_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_word,
    input  logic               in_last,
    input  logic [DATA_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] fetch_word,
    output logic               cpu_reset,
    output logic               busy,
    output logic [DATA_W:0]    loaded_count,
    output logic               overflow,
    output logic               err
);

    localparam int unsigned DEPTH = 2 ** DATA_W;
    localparam int unsigned CNT_W = DATA_W + 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_ERROR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
`endif

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 store_req_c;
    logic                 wr_en_c;
`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0]   sum_q, sum_d;
    logic                 err_q, err_d;
`endif

    // Next-state, pointer/count and flag updates
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        store_req_c = 1'b0;
        wr_en_c     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    // The last word is the checksum: compared, never stored
                    if (in_last) begin
                        if (sum_q == in_word) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        sum_d       = sum_q + in_word;
                        store_req_c = 1'b1;
                    end
`else
                    store_req_c = 1'b1;
                    if (in_last) begin
                        state_d = S_RUN;
                    end
`endif
                end
            end
            default: begin
                if (start) begin
                    state_d    = S_LOAD;
                    wptr_d     = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    err_d      = 1'b0;
`endif
                end
            end
        endcase

        // Full is judged by the count; wptr parks on the top slot instead of wrapping
        if (store_req_c) begin
            if (count_q == CNT_W'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_c = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (wptr_q != DATA_W'(DEPTH - 1)) begin
                    wptr_d = wptr_q + DATA_W'(1);
                end
            end
        end
    end

    // State, control and memory flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (wr_en_c) begin
                mem_q[wptr_q] <= in_word;
            end
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    // Status decoded from the state flop only
    assign cpu_reset    = (state_q != S_RUN);
    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD);
    assign loaded_count = count_q;
    assign overflow     = overflow_q;
`ifdef LOADER_CHECKSUM_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

    // Read returns the pre-edge word on a same-cycle write to the same address
    assign fetch_word = mem_q[fetch_addr];

endmodule
